memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Shares the single RAM port between the instruction-fetch requester (iREN) and the data requester (dREN/dWEN) that the control unit drives.
- Sits between the datapath's request unit and RAM.
- Serialises accesses with a grant FSM and gives data priority.
- A starvation guard guarantees fetch progress.

Parameters:
STARVE_LIMIT, 4, max consecutive data grants while a fetch is pending before a fetch is forced; 0 = strict data priority, no guard
WORD_W, 32, address/data width

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  reset, asynchronous, active-low
iREN  in  1  instruction read request (level, held until ihit)
iaddr  in  WORD_W  instruction address
dREN  in  1  data read request (level)
dWEN  in  1  data write request (level)
daddr  in  WORD_W  data address
dstore  in  WORD_W  data write value
ihit  out  1  one-cycle pulse: fetch complete, iload valid
iload  out  WORD_W  fetched word
dhit  out  1  one-cycle pulse: data access complete, dload valid on reads
dload  out  WORD_W  loaded word
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  WORD_W  RAM address
ramstore  out  WORD_W  RAM write data
ramload  in  WORD_W  RAM read data, valid with ram_ready
ram_ready  in  1  RAM completes the current access this cycle

Behaviour:
- Interface rule: one clock, CLK; reset nRST is asynchronous, active-low.
- Reset (nRST=0, asynchronous): state=IDLE, starve counter=0, latched addr/store/op=0. All outputs are 0 immediately. Reset mid-access drops ramREN/ramWEN at once and never produces a hit.
- States: IDLE, IACC, DACC.
- IDLE, data request present (dREN|dWEN) and guard not tripped:
  - Go to DACC; latch daddr, dstore, op (write if dWEN, else read).
  - If iREN=1, counter++ (saturating at STARVE_LIMIT); else counter=0.
- IDLE, otherwise if iREN: go to IACC, latch iaddr, counter=0.
- Guard tripped: STARVE_LIMIT>0, counter==STARVE_LIMIT, and iREN=1. Instruction is granted even if a data request is present.
- IDLE with no request: stay; all RAM enables 0.
- IACC:
  - Drive ramREN=1, ramaddr=latched iaddr.
  - On ram_ready: ihit=1, iload=ramload (combinational, same cycle); next state IDLE.
- DACC:
  - Drive ramaddr=latched daddr. Read op: ramREN=1. Write op: ramWEN=1, ramstore=latched dstore.
  - On ram_ready: dhit=1 and, for reads, dload=ramload (same cycle); next state IDLE.
- Outputs outside their active state: ihit, dhit, iload, dload, ramREN, ramWEN = 0. ramaddr, ramstore = 0 in IDLE.
- dREN and dWEN both high: treated as a write; ramREN stays 0.
- Latency: request first seen in IDLE at cycle t → RAM enable asserted from t+1 → hit in the cycle ram_ready is sampled 1. Zero-wait RAM gives a hit at t+1.
- Every access is followed by one mandatory IDLE cycle. This lets the requester deassert or advance after its hit before re-arbitration.
- Requests are sampled only in IDLE. Changes to iREN/dREN/dWEN/addresses during IACC/DACC are ignored.
- An access, once granted, always completes even if its request drops; the hit still pulses.
- ram_ready in IDLE is ignored.
- The RAM never sees ramREN and ramWEN asserted together.
- The RAM never sees an access whose enable or address changes before ram_ready.

Test Plan:
- Reset: hold nRST=0 with iREN=1 → all outputs 0. Release, ram_ready tied 1 → ramREN=1, ramaddr=iaddr=0x00000004 next cycle; ihit=1, iload=ramload=0x3C010001.
- Simultaneous iREN=1 (iaddr=0x10) and dREN=1 (daddr=0x80) in IDLE → DACC first: ramaddr=0x80, dhit, dload=ramload. IDLE for one cycle, then IACC: ramaddr=0x10, ihit.
- Write: dWEN=1, daddr=0x40, dstore=0xDEADBEEF, ram_ready low for 3 cycles → ramWEN=1, ramREN=0, ramstore=0xDEADBEEF held stable for 4 cycles. dhit pulses exactly once.
- Starvation, STARVE_LIMIT=4: iREN and dREN held high, data requester re-requests after every dhit → grant order D,D,D,D,I,D,D,D,D,I. Counter resets after each I.
- Request drop: grant IACC, deassert iREN, ram_ready after 2 cycles → ihit still pulses once; then IDLE.
- Async reset mid-DACC: assert nRST=0 between clock edges → ramWEN/ramREN fall immediately, no dhit. After release, the first grant is re-arbitrated from IDLE.

Source files
------------

// File: rtl/memory_arbiter.sv
// Shares one RAM port between instruction fetch and data access; data wins unless a fetch has starved.
// Latency: a request seen in IDLE at cycle t drives the RAM from t+1; the hit comes in the ram_ready cycle.
// Backpressure: requesters hold level requests until their hit; every access waits on ram_ready, then one IDLE cycle.
module memory_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned WORD_W       = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              ihit,
    output logic [WORD_W-1:0] iload,
    output logic              dhit,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ram_ready
);

    // The counter only has to reach STARVE_LIMIT; keep at least one bit so
    // the zero-limit build still has a legal (constant-zero) register.
    localparam int unsigned     CNT_W   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    starve_cnt;
    logic [CNT_W-1:0]    starve_cnt_nxt;
    logic [WORD_W-1:0]   addr_lat;
    logic [WORD_W-1:0]   addr_lat_nxt;
    logic [WORD_W-1:0]   store_lat;
    logic [WORD_W-1:0]   store_lat_nxt;
    logic                op_wr;
    logic                op_wr_nxt;

    logic                data_req;
    logic                guard_trip;

    assign data_req = dREN | dWEN;

    // A fetch is forced only when it is actually waiting and the data side
    // has already used up its run of consecutive grants.
    assign guard_trip = (STARVE_LIMIT > 0) && (starve_cnt == CNT_MAX) && iREN;

    // State, starvation counter and the latched access, all cleared by reset
    // so an interrupted access can never resume or complete afterwards.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            addr_lat   <= '0;
            store_lat  <= '0;
            op_wr      <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
            addr_lat   <= addr_lat_nxt;
            store_lat  <= store_lat_nxt;
            op_wr      <= op_wr_nxt;
        end
    end

    // Arbitration happens only in IDLE; an access in flight ignores its
    // requester and leaves only on ram_ready, which forces one IDLE cycle.
    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        addr_lat_nxt   = addr_lat;
        store_lat_nxt  = store_lat;
        op_wr_nxt      = op_wr;

        case (state)
            IDLE: begin
                if (data_req && !guard_trip) begin
                    state_nxt     = DACC;
                    addr_lat_nxt  = daddr;
                    store_lat_nxt = dstore;
                    // Read and write together resolve to a write.
                    op_wr_nxt     = dWEN;
                    if (iREN) begin
                        if (starve_cnt != CNT_MAX) begin
                            starve_cnt_nxt = starve_cnt + 1'b1;
                        end
                    end else begin
                        starve_cnt_nxt = '0;
                    end
                end else if (iREN) begin
                    state_nxt      = IACC;
                    addr_lat_nxt   = iaddr;
                    starve_cnt_nxt = '0;
                end
            end
            IACC: begin
                if (ram_ready) begin
                    state_nxt = IDLE;
                end
            end
            DACC: begin
                if (ram_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // RAM drive and hit generation decode straight from the registered state,
    // so reset removes every enable and hit without waiting for a clock.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ihit     = 1'b0;
        iload    = '0;
        dhit     = 1'b0;
        dload    = '0;

        case (state)
            IACC: begin
                ramREN  = 1'b1;
                ramaddr = addr_lat;
                if (ram_ready) begin
                    ihit  = 1'b1;
                    iload = ramload;
                end
            end
            DACC: begin
                ramaddr = addr_lat;
                if (op_wr) begin
                    ramWEN   = 1'b1;
                    ramstore = store_lat;
                end else begin
                    ramREN   = 1'b1;
                end
                if (ram_ready) begin
                    dhit = 1'b1;
                    if (!op_wr) begin
                        dload = ramload;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: reset, priority, writes, starvation guard, request drop, async reset.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// Expected values are written out by hand for each scenario.
module tb_memory_arbiter;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        ihit;
    logic [31:0] iload;
    logic        dhit;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ready;

    int n_checks;
    int n_fail;

    memory_arbiter #(
        .STARVE_LIMIT(4),
        .WORD_W      (32)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .ihit     (ihit),
        .iload    (iload),
        .dhit     (dhit),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ram_ready(ram_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST      = 1'b0;
        iREN      = 1'b1;
        iaddr     = 32'h0000_0004;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        daddr     = 32'h0;
        dstore    = 32'h0;
        ram_ready = 1'b1;
        ramload   = 32'h3C01_0001;
        cyc();
        cyc();
        #1;
        n_checks++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000", {ihit, dhit, ramREN, ramWEN});
        end
        n_checks++;
        if ({ramaddr, ramstore, iload, dload} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_buses: got %h want 0", {ramaddr, ramstore, iload, dload});
        end
        nRST = 1'b1;
        cyc();
        #1;
        n_checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h4) begin
            n_fail++;
            $display("FAIL reset_first_fetch: got ren=%b addr=%h want ren=1 addr=00000004", ramREN, ramaddr);
        end
        n_checks++;
        if (ihit !== 1'b1 || iload !== 32'h3C01_0001) begin
            n_fail++;
            $display("FAIL reset_first_ihit: got ihit=%b iload=%h want 1 3c010001", ihit, iload);
        end
        iREN = 1'b0;
        cyc();
        #1;
        n_checks++;
        if (ihit !== 1'b0 || ramREN !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_post_idle: got ihit=%b ren=%b want 0 0", ihit, ramREN);
        end
    endtask

    task automatic test_idle_ready();
        ram_ready = 1'b1;
        ramload   = 32'h5555_AAAA;
        cyc();
        #1;
        n_checks++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b0000 || ramaddr !== 32'h0) begin
            n_fail++;
            $display("FAIL idle_ready_ignored: got %b addr=%h want 0000 0", {ihit, dhit, ramREN, ramWEN}, ramaddr);
        end
    endtask

    task automatic test_priority();
        iREN      = 1'b1;
        iaddr     = 32'h10;
        dREN      = 1'b1;
        daddr     = 32'h80;
        ram_ready = 1'b1;
        ramload   = 32'h1111_2222;
        cyc();
        #1;
        n_checks++;
        if (ramaddr !== 32'h80 || ramREN !== 1'b1 || ihit !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_data_first: got addr=%h ren=%b ihit=%b want 80 1 0", ramaddr, ramREN, ihit);
        end
        n_checks++;
        if (dhit !== 1'b1 || dload !== 32'h1111_2222) begin
            n_fail++;
            $display("FAIL prio_dload: got dhit=%b dload=%h want 1 11112222", dhit, dload);
        end
        dREN = 1'b0;
        cyc();
        #1;
        n_checks++;
        if (ramREN !== 1'b0 || ramaddr !== 32'h0 || dhit !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_gap_idle: got ren=%b addr=%h dhit=%b want 0 0 0", ramREN, ramaddr, dhit);
        end
        ramload = 32'h3333_4444;
        cyc();
        #1;
        n_checks++;
        if (ramaddr !== 32'h10 || ihit !== 1'b1 || iload !== 32'h3333_4444) begin
            n_fail++;
            $display("FAIL prio_fetch_next: got addr=%h ihit=%b iload=%h want 10 1 33334444", ramaddr, ihit, iload);
        end
        iREN = 1'b0;
        cyc();
    endtask

    task automatic test_write();
        int hits;
        hits      = 0;
        dWEN      = 1'b1;
        daddr     = 32'h40;
        dstore    = 32'hDEAD_BEEF;
        ram_ready = 1'b0;
        cyc();
        // Requester changes mid-access must not disturb the latched write.
        dWEN   = 1'b0;
        daddr  = 32'h0;
        dstore = 32'h0;
        for (int k = 0; k < 4; k++) begin
            ram_ready = (k == 3);
            #1;
            n_checks++;
            if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h40 || ramstore !== 32'hDEAD_BEEF) begin
                n_fail++;
                $display("FAIL write_hold[%0d]: got wen=%b ren=%b addr=%h st=%h want 1 0 40 deadbeef",
                         k, ramWEN, ramREN, ramaddr, ramstore);
            end
            n_checks++;
            if (dhit !== (k == 3) || dload !== 32'h0) begin
                n_fail++;
                $display("FAIL write_dhit[%0d]: got dhit=%b dload=%h want %b 0", k, dhit, dload, (k == 3));
            end
            if (dhit === 1'b1) hits++;
            cyc();
        end
        ram_ready = 1'b0;
        #1;
        n_checks++;
        if (hits != 1 || ramWEN !== 1'b0 || dhit !== 1'b0) begin
            n_fail++;
            $display("FAIL write_single_hit: got hits=%0d wen=%b dhit=%b want 1 0 0", hits, ramWEN, dhit);
        end
    endtask

    task automatic test_both_high();
        dREN      = 1'b1;
        dWEN      = 1'b1;
        daddr     = 32'h70;
        dstore    = 32'h1234_5678;
        ram_ready = 1'b1;
        ramload   = 32'hFFFF_0000;
        cyc();
        dREN = 1'b0;
        dWEN = 1'b0;
        #1;
        n_checks++;
        if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL both_high_write: got wen=%b ren=%b st=%h want 1 0 12345678", ramWEN, ramREN, ramstore);
        end
        n_checks++;
        if (dhit !== 1'b1 || dload !== 32'h0) begin
            n_fail++;
            $display("FAIL both_high_dhit: got dhit=%b dload=%h want 1 0", dhit, dload);
        end
        cyc();
    endtask

    task automatic test_request_drop();
        iREN      = 1'b1;
        iaddr     = 32'h20;
        ram_ready = 1'b0;
        ramload   = 32'hA5A5_0F0F;
        cyc();
        iREN  = 1'b0;
        iaddr = 32'h0;
        for (int k = 0; k < 3; k++) begin
            ram_ready = (k == 2);
            #1;
            n_checks++;
            if (ramREN !== 1'b1 || ramaddr !== 32'h20 || ihit !== (k == 2)) begin
                n_fail++;
                $display("FAIL drop_fetch[%0d]: got ren=%b addr=%h ihit=%b want 1 20 %b", k, ramREN, ramaddr, ihit, (k == 2));
            end
            cyc();
        end
        ram_ready = 1'b0;
        #1;
        n_checks++;
        if (ramREN !== 1'b0 || ihit !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_back_idle: got ren=%b ihit=%b want 0 0", ramREN, ihit);
        end
    endtask

    task automatic test_starvation();
        string exp_seq;
        byte   got;
        int    g;
        int    budget;
        exp_seq   = "DDDDIDDDDI";
        g         = 0;
        budget    = 60;
        iREN      = 1'b1;
        iaddr     = 32'h100;
        dREN      = 1'b1;
        daddr     = 32'h200;
        ram_ready = 1'b1;
        while (g < 10 && budget > 0) begin
            cyc();
            #1;
            budget--;
            if (ihit === 1'b1 || dhit === 1'b1) begin
                got = (ihit === 1'b1) ? "I" : "D";
                n_checks++;
                if (got != exp_seq[g]) begin
                    n_fail++;
                    $display("FAIL starve_order[%0d]: got %s want %s", g, got, exp_seq[g]);
                end
                g++;
            end
        end
        n_checks++;
        if (g != 10) begin
            n_fail++;
            $display("FAIL starve_budget: got %0d grants want 10", g);
        end
        iREN = 1'b0;
        dREN = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_async_reset();
        dWEN      = 1'b1;
        daddr     = 32'h60;
        dstore    = 32'hCAFE_F00D;
        ram_ready = 1'b0;
        cyc();
        dWEN = 1'b0;
        #1;
        n_checks++;
        if (ramWEN !== 1'b1 || ramaddr !== 32'h60) begin
            n_fail++;
            $display("FAIL areset_pre: got wen=%b addr=%h want 1 60", ramWEN, ramaddr);
        end
        #1;
        nRST      = 1'b0;
        ram_ready = 1'b1;
        #1;
        n_checks++;
        if ({ramWEN, ramREN, dhit} !== 3'b000 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin
            n_fail++;
            $display("FAIL areset_drop: got wen/ren/dhit=%b addr=%h st=%h want 000 0 0",
                     {ramWEN, ramREN, dhit}, ramaddr, ramstore);
        end
        cyc();
        nRST    = 1'b1;
        iREN    = 1'b1;
        iaddr   = 32'h44;
        ramload = 32'h0BAD_CAFE;
        cyc();
        #1;
        n_checks++;
        if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h44 || ihit !== 1'b1 || dhit !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_rearb: got ren=%b wen=%b addr=%h ihit=%b dhit=%b want 1 0 44 1 0",
                     ramREN, ramWEN, ramaddr, ihit, dhit);
        end
        iREN = 1'b0;
        cyc();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_idle_ready();
        test_priority();
        test_write();
        test_both_high();
        test_request_drop();
        test_starvation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
